heartbeat_monitor: RTL and testbench

Receive-side checker for the heartbeat produced by the clock divider. It watches a beat signal in the same `clk` domain and measures the cycle count between rising edges. It declares lock after a run of in-window periods, and flags early, late or lost beats. It sits beside the divider so that system logic and the bench can confirm the divider is alive and on frequency.

---
 rtl/heartbeat_pkg.sv | 25 ++
 rtl/beat_edge_detect.sv | 20 ++
 rtl/heartbeat_monitor.sv | 142 ++++++++++++++
 tb/tb_heartbeat_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/heartbeat_pkg.sv
// Shared types and helpers for the heartbeat monitor: FSM state encoding and
// the acceptance-window calculation.
package heartbeat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ANCHOR,
    ACQUIRE,
    LOCKED
  } hbState_e;

  typedef struct packed {
    int unsigned lo;
    int unsigned hi;
  } window_t;

  function automatic window_t calcWindow(input int unsigned expected,
                                         input int unsigned tolerance);
    window_t w;
    w.lo = expected - tolerance;
    w.hi = expected + tolerance;
    return w;
  endfunction

endpackage

// File: rtl/beat_edge_detect.sv
// Registers the incoming beat every cycle and flags its rising edges.
module beat_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic beat_i,
  output logic rise_o
);

  logic beat_q;

  // Tracks the beat even while the monitor is disabled, so a level that rose
  // during disable is never mistaken for a fresh edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) beat_q <= 1'b0;
    else          beat_q <= beat_i;
  end

  assign rise_o = beat_i & ~beat_q;

endmodule

// File: rtl/heartbeat_monitor.sv
// Receive-side heartbeat checker: measures beat periods, declares lock after a
// run of in-window periods and reports early, late and sticky alarm faults.
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int unsigned EXPECTED   = 50_000,
  parameter int unsigned TOLERANCE  = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             beat_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic             alarm,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  localparam window_t          WIN    = calcWindow(EXPECTED, TOLERANCE);
  localparam logic [CNT_W-1:0] LO     = CNT_W'(WIN.lo);
  localparam logic [CNT_W-1:0] HI     = CNT_W'(WIN.hi);
  localparam int               GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

  hbState_e          state_q, state_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic [GOOD_W-1:0] goodCnt_q, goodCnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              locked_q, locked_d;
  logic              errEarly_q, errEarly_d;
  logic              errLate_q, errLate_d;
  logic              alarm_q, alarm_d;
  logic              periodValid_q, periodValid_d;

  logic              rise;
  logic              measuring;
  logic              earlyHit;
  logic              goodHit;
  logic              timeoutHit;
  logic              fault;
  logic [GOOD_W-1:0] goodInc;

  beat_edge_detect uEdge (
    .clk     (clk),
    .reset_n (reset_n),
    .beat_i  (beat_in),
    .rise_o  (rise)
  );

  // The timeout fires at gap==HI, so any edge seen while measuring has gap<=HI.
  assign measuring  = enable & ((state_q == ACQUIRE) | (state_q == LOCKED));
  assign earlyHit   = measuring & rise & (gap_q < LO);
  assign goodHit    = measuring & rise & (gap_q >= LO);
  assign timeoutHit = measuring & ~rise & (gap_q == HI);
  assign fault      = earlyHit | timeoutHit;
  assign goodInc    = (goodCnt_q == GOOD_MAX) ? goodCnt_q : goodCnt_q + GOOD_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      goodCnt_q     <= '0;
      period_q      <= '0;
      locked_q      <= 1'b0;
      errEarly_q    <= 1'b0;
      errLate_q     <= 1'b0;
      alarm_q       <= 1'b0;
      periodValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      goodCnt_q     <= goodCnt_d;
      period_q      <= period_d;
      locked_q      <= locked_d;
      errEarly_q    <= errEarly_d;
      errLate_q     <= errLate_d;
      alarm_q       <= alarm_d;
      periodValid_q <= periodValid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ANCHOR;
        ANCHOR:  if (rise) state_d = ACQUIRE;
        ACQUIRE, LOCKED: begin
          if (earlyHit)        state_d = ACQUIRE;
          else if (timeoutHit) state_d = ANCHOR;
          else if (goodHit && (goodInc == GOOD_MAX)) state_d = LOCKED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Set beats clear on the alarm, hence the OR after the clear mask.
  always_comb begin
    gap_d         = (gap_q == '1) ? gap_q : gap_q + CNT_W'(1);
    if (rise) gap_d = CNT_W'(1);
    goodCnt_d     = goodCnt_q;
    locked_d      = locked_q;
    period_d      = period_q;
    periodValid_d = 1'b0;
    errEarly_d    = earlyHit;
    errLate_d     = timeoutHit;
    alarm_d       = (alarm_q & ~clear) | (fault & (state_q == LOCKED));
    if (!enable || (state_q == IDLE)) begin
      gap_d     = '0;
      goodCnt_d = '0;
      locked_d  = 1'b0;
    end else begin
      if (measuring && rise) begin
        period_d      = gap_q;
        periodValid_d = 1'b1;
      end
      if (fault) begin
        goodCnt_d = '0;
        locked_d  = 1'b0;
      end else if (goodHit) begin
        goodCnt_d = goodInc;
        if (goodInc == GOOD_MAX) locked_d = 1'b1;
      end
    end
  end

  assign locked       = locked_q;
  assign err_early    = errEarly_q;
  assign err_late     = errLate_q;
  assign alarm        = alarm_q;
  assign period       = period_q;
  assign period_valid = periodValid_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed and randomized bench for heartbeat_monitor with a timestamp-based
// reference model (EXPECTED=10, TOLERANCE=1, LOCK_COUNT=3 -> window 9..11).
module tb_heartbeat_monitor;

  localparam int EXP = 10;
  localparam int TOL = 1;
  localparam int LC  = 3;
  localparam int CW  = 8;
  localparam int LO  = EXP - TOL;
  localparam int HI  = EXP + TOL;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          beat_in;
  logic          clear;
  logic          locked;
  logic          err_early;
  logic          err_late;
  logic          alarm;
  logic [CW-1:0] period;
  logic          period_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: edges are timestamped, periods are timestamp differences.
  bit mPrevBeat, mArmed, mHaveRef;
  int mCyc, mLastEdge, mRun;
  bit eLocked, eEarly, eLate, eAlarm, ePv;
  int ePeriod;

  heartbeat_monitor #(
    .EXPECTED  (EXP),
    .TOLERANCE (TOL),
    .LOCK_COUNT(LC),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .beat_in     (beat_in),
    .clear       (clear),
    .locked      (locked),
    .err_early   (err_early),
    .err_late    (err_late),
    .alarm       (alarm),
    .period      (period),
    .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, mCyc);
    end
  endtask

  task automatic modelReset();
    mPrevBeat = 0; mArmed = 0; mHaveRef = 0; mRun = 0; mLastEdge = 0;
    eLocked = 0; eEarly = 0; eLate = 0; eAlarm = 0; ePv = 0; ePeriod = 0;
  endtask

  task automatic modelStep(input logic beat, input logic en, input logic clr);
    bit rise, fault, wasLocked;
    int age;
    mCyc++;
    if (!reset_n) begin
      modelReset();
      return;
    end
    rise = beat && !mPrevBeat;
    mPrevBeat = beat;
    ePv = 0; eEarly = 0; eLate = 0; fault = 0;
    wasLocked = eLocked;
    if (clr) eAlarm = 0;
    if (!en) begin
      mArmed = 0; mHaveRef = 0; mRun = 0;
    end else if (!mArmed) begin
      mArmed = 1;
    end else if (!mHaveRef) begin
      if (rise) begin
        mHaveRef = 1;
        mLastEdge = mCyc;
      end
    end else begin
      age = mCyc - mLastEdge;
      if (rise) begin
        ePv = 1;
        ePeriod = age;
        mLastEdge = mCyc;
        if (age < LO) begin
          eEarly = 1;
          fault = 1;
        end else if (mRun < LC) begin
          mRun++;
        end
      end else if (age == HI) begin
        eLate = 1;
        fault = 1;
        mHaveRef = 0;
      end
    end
    if (fault) begin
      mRun = 0;
      if (wasLocked) eAlarm = 1;
    end
    eLocked = (mRun >= LC);
  endtask

  task automatic compareAll();
    checkOutput("locked",       32'(locked),       32'(eLocked));
    checkOutput("err_early",    32'(err_early),    32'(eEarly));
    checkOutput("err_late",     32'(err_late),     32'(eLate));
    checkOutput("alarm",        32'(alarm),        32'(eAlarm));
    checkOutput("period",       32'(period),       32'(ePeriod));
    checkOutput("period_valid", 32'(period_valid), 32'(ePv));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic applyStimulus(input logic beat, input logic en, input logic clr);
    beat_in = beat;
    enable  = en;
    clear   = clr;
    @(posedge clk);
    modelStep(beat, en, clr);
    @(negedge clk);
    compareAll();
  endtask

  task automatic beatAfter(input int p, input logic clrOnEdge);
    for (int i = 1; i < p; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, clrOnEdge);
  endtask

  initial begin
    int lateCount;
    int lateIdx;
    int g;
    int w;

    reset_n = 1'b0; enable = 1'b0; beat_in = 1'b0; clear = 1'b0;
    mCyc = 0;
    modelReset();
    @(negedge clk);

    $display("[TB] reset with toggling beat");
    for (int i = 0; i < 6; i++) applyStimulus(1'(i), 1'b1, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'(i), 1'b0, 1'b0);

    $display("[TB] nominal lock");
    applyStimulus(1'b0, 1'b1, 1'b0);
    beatAfter(10, 1'b0);
    checkOutput("anchorPv", 32'(period_valid), 0);
    beatAfter(10, 1'b0);
    checkOutput("nomPv2", 32'(period_valid), 1);
    checkOutput("nomPeriod2", 32'(period), 10);
    beatAfter(10, 1'b0);
    checkOutput("nomLocked3", 32'(locked), 0);
    beatAfter(10, 1'b0);
    checkOutput("nomLocked4", 32'(locked), 1);

    $display("[TB] early beat while locked");
    beatAfter(8, 1'b0);
    checkOutput("earlyPulse", 32'(err_early), 1);
    checkOutput("earlyPeriod", 32'(period), 8);
    checkOutput("earlyLocked", 32'(locked), 0);
    checkOutput("earlyAlarm", 32'(alarm), 1);
    beatAfter(10, 1'b0);
    beatAfter(10, 1'b0);
    checkOutput("relockPending", 32'(locked), 0);
    beatAfter(10, 1'b0);
    checkOutput("relockEarly", 32'(locked), 1);

    $display("[TB] lost beat while locked");
    lateCount = 0;
    lateIdx = 0;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b0, 1'b1, k == 1);
      if (k == 1) checkOutput("clearAlarm", 32'(alarm), 0);
      if (err_late) begin
        lateCount++;
        lateIdx = k;
      end
    end
    checkOutput("lateCount", 32'(lateCount), 1);
    checkOutput("lateCycle", 32'(lateIdx), 11);
    checkOutput("lateAlarm", 32'(alarm), 1);
    checkOutput("lateLocked", 32'(locked), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("clearAlarm2", 32'(alarm), 0);

    $display("[TB] resume with boundary periods");
    beatAfter(4, 1'b0);
    checkOutput("resumeAnchorPv", 32'(period_valid), 0);
    beatAfter(11, 1'b0);
    checkOutput("bndPeriod11", 32'(period), 11);
    checkOutput("bndNoLate", 32'(err_late), 0);
    beatAfter(9, 1'b0);
    checkOutput("bndPeriod9", 32'(period), 9);
    checkOutput("bndNoEarly", 32'(err_early), 0);
    beatAfter(11, 1'b0);
    checkOutput("bndLocked", 32'(locked), 1);
    checkOutput("bndAlarm", 32'(alarm), 0);
    beatAfter(5, 1'b1);
    checkOutput("setWinsEarly", 32'(err_early), 1);
    checkOutput("setWinsAlarm", 32'(alarm), 1);

    $display("[TB] enable handling");
    for (int i = 0; i < 3; i++) beatAfter(10, 1'b0);
    checkOutput("preDisLocked", 32'(locked), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("disLocked", 32'(locked), 0);
    checkOutput("disEarly", 32'(err_early), 0);
    checkOutput("disLate", 32'(err_late), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("heldLevelAnchorPv", 32'(period_valid), 0);
    for (int i = 0; i < 3; i++) beatAfter(10, 1'b0);
    checkOutput("heldLevelLocked", 32'(locked), 1);

    $display("[TB] reset while locked");
    reset_n = 1'b0;
    #1;
    checkOutput("rstLocked", 32'(locked), 0);
    checkOutput("rstAlarm", 32'(alarm), 0);
    checkOutput("rstPeriod", 32'(period), 0);
    checkOutput("rstPv", 32'(period_valid), 0);
    checkOutput("rstEarly", 32'(err_early), 0);
    checkOutput("rstLate", 32'(err_late), 0);
    modelReset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;

    $display("[TB] randomized beats");
    for (int e = 0; e < 80; e++) begin
      if ($urandom_range(0, 9) == 0) begin
        int n;
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      g = $urandom_range(6, 14);
      w = $urandom_range(1, 2);
      for (int i = 0; i < g; i++)
        applyStimulus(i >= g - w, 1'b1, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
